// File: rtl/xcache_bus_mon.sv
// xcache_bus_mon: passive monitor for NUM_CACHE private caches on the snooping bus.
// Per channel it pairs bus requests with responses, times them out, checks the
// CPU-side hold-while-wait handshake and keeps sticky error bits plus a
// saturating count of completed bus transactions.
module xcache_bus_mon #(
  parameter int NUM_CACHE  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 512,
  parameter int TIMEOUT    = 64,
  parameter int CNT_WIDTH  = 16,
  localparam int LA = ADDR_WIDTH - $clog2(LINE_WIDTH / 8)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_CACHE-1:0]            cpu2cac_rd,
  input  logic [NUM_CACHE-1:0]            cpu2cac_wr,
  input  logic [NUM_CACHE*ADDR_WIDTH-1:0] cpu2cac_addr,
  input  logic [NUM_CACHE-1:0]            cac2cpu_wait,
  input  logic [NUM_CACHE*2-1:0]          cac2bus_bus_req,
  input  logic [NUM_CACHE*LA-1:0]         cac2bus_addr,
  input  logic [NUM_CACHE*2-1:0]          bus2cac_bus_rsp,
  input  logic [NUM_CACHE*LA-1:0]         bus2cac_addr,
  input  logic                            err_clr,
  output logic [NUM_CACHE-1:0]            outstanding,
  output logic [NUM_CACHE*6-1:0]          err_vec,
  output logic                            err_any,
  output logic [NUM_CACHE*CNT_WIDTH-1:0]  txn_cnt
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  // Error bit positions within a channel's 6-bit slice
  localparam int E_CPU = 0;
  localparam int E_DUP = 1;
  localparam int E_ORPH = 2;
  localparam int E_ILL = 3;
  localparam int E_ADDR = 4;
  localparam int E_TMO = 5;

  typedef enum logic {ST_IDLE = 1'b0, ST_OPEN = 1'b1} state_t;

  // Next-cycle error state of every channel, used to keep err_any aligned with err_vec
  logic [NUM_CACHE*6-1:0] w_err_next_all;
  logic                   r_err_any;

  for (genvar gi = 0; gi < NUM_CACHE; gi++) begin : g_ch
    logic                  w_rd, w_wr, w_wait;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [1:0]            w_req, w_rsp;
    logic [LA-1:0]         w_req_addr, w_rsp_addr;

    assign w_rd       = cpu2cac_rd[gi];
    assign w_wr       = cpu2cac_wr[gi];
    assign w_wait     = cac2cpu_wait[gi];
    assign w_addr     = cpu2cac_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_req      = cac2bus_bus_req[gi*2 +: 2];
    assign w_rsp      = bus2cac_bus_rsp[gi*2 +: 2];
    assign w_req_addr = cac2bus_addr[gi*LA +: LA];
    assign w_rsp_addr = bus2cac_addr[gi*LA +: LA];

    state_t                r_state, w_state_next;
    logic [LA-1:0]         r_line;
    logic [TW-1:0]         r_timer;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [5:0]            r_err, w_err_set, w_err_next;
    logic                  r_rd_q, r_wr_q, r_wait_q;
    logic [ADDR_WIDTH-1:0] r_addr_q;
    logic                  w_open, w_close, w_req_v, w_rsp_ok, w_cpu_viol;

    // CPU check: never rd and wr together; a stalled request must hold still
    assign w_cpu_viol = (w_rd & w_wr) |
                        ((r_rd_q | r_wr_q) & r_wait_q &
                         ((w_rd != r_rd_q) | (w_wr != r_wr_q) | (w_addr != r_addr_q)));

    // Bus FSM next state plus the error events raised this cycle
    always_comb begin
      w_state_next = r_state;
      w_open       = 1'b0;
      w_close      = 1'b0;
      w_err_set    = '0;
      w_req_v      = (w_req != 2'b00);
      w_rsp_ok     = (w_rsp == 2'b01) || (w_rsp == 2'b10);
      case (r_state)
        ST_IDLE: begin
          if (w_req_v) begin
            w_state_next = ST_OPEN;
            w_open       = 1'b1;
          end
          if (w_rsp_ok) w_err_set[E_ORPH] = 1'b1;
        end
        ST_OPEN: begin
          if (w_rsp_ok) begin
            // Response closes the transaction; a same-cycle request reopens it
            w_close = 1'b1;
            if (w_rsp_addr != r_line) w_err_set[E_ADDR] = 1'b1;
            if (w_req_v) w_open = 1'b1;
            else         w_state_next = ST_IDLE;
          end else begin
            if (w_req_v) w_err_set[E_DUP] = 1'b1;
            if (r_timer == TMAX) begin
              w_err_set[E_TMO] = 1'b1;
              w_state_next     = ST_IDLE;
            end
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
      if (w_rsp == 2'b11) w_err_set[E_ILL] = 1'b1;
      w_err_set[E_CPU] = w_cpu_viol;
      // A new error in the clearing cycle survives the clear
      w_err_next = (r_err & ~{6{err_clr}}) | w_err_set;
    end

    // Bus FSM state register
    always_ff @(posedge clk) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_next;
    end

    // Latched line, timer, counter, sticky errors and one cycle of CPU history
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_line   <= '0;
        r_timer  <= '0;
        r_cnt    <= '0;
        r_err    <= '0;
        r_rd_q   <= 1'b0;
        r_wr_q   <= 1'b0;
        r_wait_q <= 1'b0;
        r_addr_q <= '0;
      end else begin
        if (w_open) begin
          r_line  <= w_req_addr;
          r_timer <= '0;
        end else if (r_state == ST_OPEN) begin
          r_timer <= r_timer + 1'b1;
        end
        if (w_close && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
        r_err    <= w_err_next;
        r_rd_q   <= w_rd;
        r_wr_q   <= w_wr;
        r_wait_q <= w_wait;
        r_addr_q <= w_addr;
      end
    end

    assign outstanding[gi]                    = (r_state == ST_OPEN);
    assign err_vec[gi*6 +: 6]                 = r_err;
    assign txn_cnt[gi*CNT_WIDTH +: CNT_WIDTH] = r_cnt;
    assign w_err_next_all[gi*6 +: 6]          = w_err_next;
  end

  // Summary flag registered from the same next-state as err_vec
  always_ff @(posedge clk) begin
    if (!rst_n) r_err_any <= 1'b0;
    else        r_err_any <= |w_err_next_all;
  end

  assign err_any = r_err_any;

endmodule

// File: tb/tb_xcache_bus_mon.sv
// Self-checking bench for xcache_bus_mon: table-driven single-cycle vectors plus
// hand-written multi-cycle sequences, all checked through an expectation queue.
module tb_xcache_bus_mon;
  localparam int NC = 4;
  localparam int AW = 32;
  localparam int LW = 512;
  localparam int TO = 64;
  localparam int CW = 4;
  localparam int LA = AW - $clog2(LW / 8);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NC-1:0]    cpu2cac_rd, cpu2cac_wr, cac2cpu_wait;
  logic [NC*AW-1:0] cpu2cac_addr;
  logic [NC*2-1:0]  cac2bus_bus_req, bus2cac_bus_rsp;
  logic [NC*LA-1:0] cac2bus_addr, bus2cac_addr;
  logic             err_clr;
  logic [NC-1:0]    outstanding;
  logic [NC*6-1:0]  err_vec;
  logic             err_any;
  logic [NC*CW-1:0] txn_cnt;

  always #5 clk = ~clk;

  xcache_bus_mon #(
    .NUM_CACHE(NC), .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .TIMEOUT(TO), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu2cac_rd(cpu2cac_rd), .cpu2cac_wr(cpu2cac_wr), .cpu2cac_addr(cpu2cac_addr),
    .cac2cpu_wait(cac2cpu_wait),
    .cac2bus_bus_req(cac2bus_bus_req), .cac2bus_addr(cac2bus_addr),
    .bus2cac_bus_rsp(bus2cac_bus_rsp), .bus2cac_addr(bus2cac_addr),
    .err_clr(err_clr),
    .outstanding(outstanding), .err_vec(err_vec), .err_any(err_any), .txn_cnt(txn_cnt)
  );

  typedef struct {
    logic [NC-1:0]    out;
    logic [NC*6-1:0]  err;
    logic             any;
    logic [NC*CW-1:0] cnt;
  } exp_t;

  typedef struct {
    string         name;
    int            ch;
    logic          rd, wr, wt;
    logic [AW-1:0] ca;
    logic [1:0]    req;
    logic [LA-1:0] ra;
    logic [1:0]    rsp;
    logic [LA-1:0] pa;
    logic          clr;
    logic          e_out;
    logic [5:0]    e_err;
    logic [CW-1:0] e_cnt;
  } vec_t;

  exp_t sb_q[$];
  exp_t x;
  vec_t tbl[$];
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input string n, input int ch, input logic rd, input logic wr,
                              input logic wt, input logic [AW-1:0] ca, input logic [1:0] req,
                              input logic [LA-1:0] ra, input logic [1:0] rsp,
                              input logic [LA-1:0] pa, input logic clr, input logic eo,
                              input logic [5:0] ee, input logic [CW-1:0] ec);
    vec_t v;
    v.name = n; v.ch = ch; v.rd = rd; v.wr = wr; v.wt = wt; v.ca = ca;
    v.req = req; v.ra = ra; v.rsp = rsp; v.pa = pa; v.clr = clr;
    v.e_out = eo; v.e_err = ee; v.e_cnt = ec;
    return v;
  endfunction

  task automatic clear_inputs();
    cpu2cac_rd = '0; cpu2cac_wr = '0; cac2cpu_wait = '0; cpu2cac_addr = '0;
    cac2bus_bus_req = '0; cac2bus_addr = '0; bus2cac_bus_rsp = '0; bus2cac_addr = '0;
    err_clr = 1'b0;
  endtask

  task automatic zero_exp();
    x.out = '0; x.err = '0; x.any = 1'b0; x.cnt = '0;
  endtask

  task automatic check(input string name);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL %s scoreboard empty", name);
      return;
    end
    e = sb_q.pop_front();
    n_chk++;
    if (outstanding !== e.out) begin
      n_fail++; $display("FAIL %s outstanding got %h want %h", name, outstanding, e.out);
    end
    n_chk++;
    if (err_vec !== e.err) begin
      n_fail++; $display("FAIL %s err_vec got %h want %h", name, err_vec, e.err);
    end
    n_chk++;
    if (err_any !== e.any) begin
      n_fail++; $display("FAIL %s err_any got %b want %b", name, err_any, e.any);
    end
    n_chk++;
    if (txn_cnt !== e.cnt) begin
      n_fail++; $display("FAIL %s txn_cnt got %h want %h", name, txn_cnt, e.cnt);
    end
  endtask

  // One clock of the currently driven stimulus, checked against the running expectation
  task automatic cyc(input string name);
    exp_t e;
    e = x;
    e.any = |x.err;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    check(name);
    $display("%0t %s out=%h err=%h any=%b cnt=%h", $time, name, outstanding, err_vec,
             err_any, txn_cnt);
    clear_inputs();
  endtask

  task automatic apply(input vec_t v);
    cpu2cac_rd[v.ch]             = v.rd;
    cpu2cac_wr[v.ch]             = v.wr;
    cac2cpu_wait[v.ch]           = v.wt;
    cpu2cac_addr[v.ch*AW +: AW]  = v.ca;
    cac2bus_bus_req[v.ch*2 +: 2] = v.req;
    cac2bus_addr[v.ch*LA +: LA]  = v.ra;
    bus2cac_bus_rsp[v.ch*2 +: 2] = v.rsp;
    bus2cac_addr[v.ch*LA +: LA]  = v.pa;
    err_clr                      = v.clr;
    if (v.clr) x.err = '0;
    x.out[v.ch]           = v.e_out;
    x.err[v.ch*6 +: 6]    = v.e_err;
    x.cnt[v.ch*CW +: CW]  = v.e_cnt;
    cyc(v.name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    zero_exp();

    //            name           ch rd wr wt ca      req    ra       rsp    pa       clr eo ee         ec
    // ch0: read at line 0x1A3, answered 5 cycles later
    tbl.push_back(mk("c0_req",    0, 0, 0, 0, 32'h0, 2'b01, 26'h1A3, 2'b00, 26'h0,   0, 1, 6'b000000, 4'd0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk("c0_open", 0, 0, 0, 0, 32'h0, 2'b00, 26'h0,   2'b00, 26'h0,   0, 1, 6'b000000, 4'd0));
    tbl.push_back(mk("c0_rsp",    0, 0, 0, 0, 32'h0, 2'b00, 26'h0,   2'b01, 26'h1A3, 0, 0, 6'b000000, 4'd1));
    // ch3: orphan, illegal, address mismatch, clear-vs-set
    tbl.push_back(mk("c3_orphan", 3, 0, 0, 0, 32'h0, 2'b00, 26'h0,   2'b10, 26'h0,   0, 0, 6'b000100, 4'd0));
    tbl.push_back(mk("c3_illegal",3, 0, 0, 0, 32'h0, 2'b00, 26'h0,   2'b11, 26'h0,   0, 0, 6'b001100, 4'd0));
    tbl.push_back(mk("c3_req",    3, 0, 0, 0, 32'h0, 2'b01, 26'h3,   2'b00, 26'h0,   0, 1, 6'b001100, 4'd0));
    tbl.push_back(mk("c3_mism",   3, 0, 0, 0, 32'h0, 2'b00, 26'h0,   2'b01, 26'h2,   0, 0, 6'b011100, 4'd1));
    tbl.push_back(mk("c3_clr_set",3, 0, 0, 0, 32'h0, 2'b00, 26'h0,   2'b11, 26'h0,   1, 0, 6'b001000, 4'd1));
    tbl.push_back(mk("c3_clr",    3, 0, 0, 0, 32'h0, 2'b00, 26'h0,   2'b00, 26'h0,   1, 0, 6'b000000, 4'd1));
    // ch1: back-to-back close/open, then a duplicate request that must not replace the open one
    tbl.push_back(mk("c1_req",    1, 0, 0, 0, 32'h0, 2'b01, 26'h10,  2'b00, 26'h0,   0, 1, 6'b000000, 4'd0));
    tbl.push_back(mk("c1_hold",   1, 0, 0, 0, 32'h0, 2'b00, 26'h0,   2'b00, 26'h0,   0, 1, 6'b000000, 4'd0));
    tbl.push_back(mk("c1_b2b",    1, 0, 0, 0, 32'h0, 2'b11, 26'h20,  2'b01, 26'h10,  0, 1, 6'b000000, 4'd1));
    tbl.push_back(mk("c1_dup",    1, 0, 0, 0, 32'h0, 2'b10, 26'h30,  2'b00, 26'h0,   0, 1, 6'b000010, 4'd1));
    tbl.push_back(mk("c1_rsp",    1, 0, 0, 0, 32'h0, 2'b00, 26'h0,   2'b10, 26'h20,  0, 0, 6'b000010, 4'd2));
    tbl.push_back(mk("c1_clr",    1, 0, 0, 0, 32'h0, 2'b00, 26'h0,   2'b00, 26'h0,   1, 0, 6'b000000, 4'd2));
    // ch0: CPU handshake checks
    tbl.push_back(mk("cpu_wait",  0, 1, 0, 1, 32'h40,2'b00, 26'h0,   2'b00, 26'h0,   0, 0, 6'b000000, 4'd1));
    tbl.push_back(mk("cpu_chg",   0, 1, 0, 1, 32'h44,2'b00, 26'h0,   2'b00, 26'h0,   0, 0, 6'b000001, 4'd1));
    tbl.push_back(mk("cpu_rel",   0, 1, 0, 0, 32'h44,2'b00, 26'h0,   2'b00, 26'h0,   1, 0, 6'b000000, 4'd1));
    tbl.push_back(mk("cpu_idle",  0, 0, 0, 0, 32'h0, 2'b00, 26'h0,   2'b00, 26'h0,   0, 0, 6'b000000, 4'd1));
    tbl.push_back(mk("cpu_wonly", 0, 0, 0, 1, 32'h0, 2'b00, 26'h0,   2'b00, 26'h0,   0, 0, 6'b000000, 4'd1));
    tbl.push_back(mk("cpu_new",   0, 1, 0, 0, 32'h80,2'b00, 26'h0,   2'b00, 26'h0,   0, 0, 6'b000000, 4'd1));
    tbl.push_back(mk("cpu_rdwr",  0, 1, 1, 0, 32'h80,2'b00, 26'h0,   2'b00, 26'h0,   0, 0, 6'b000001, 4'd1));
    tbl.push_back(mk("cpu_clr",   0, 0, 0, 0, 32'h0, 2'b00, 26'h0,   2'b00, 26'h0,   1, 0, 6'b000000, 4'd1));

    // Reset state
    rst_n = 1'b0;
    cyc("reset0");
    cyc("reset1");
    rst_n = 1'b1;

    foreach (tbl[i]) apply(tbl[i]);

    // ch2: no response for TIMEOUT cycles
    cac2bus_bus_req[5:4] = 2'b10;
    cac2bus_addr[2*LA +: LA] = 26'h55;
    x.out[2] = 1'b1;
    cyc("c2_req");
    for (int k = 1; k < TO; k++) cyc("c2_open");
    x.out[2] = 1'b0;
    x.err[2*6 + 5] = 1'b1;
    cyc("c2_timeout");
    err_clr = 1'b1;
    x.err = '0;
    cyc("c2_clr");

    // ch2: response lands exactly on the timeout cycle and wins
    cac2bus_bus_req[5:4] = 2'b01;
    cac2bus_addr[2*LA +: LA] = 26'h55;
    x.out[2] = 1'b1;
    cyc("c2_req2");
    for (int k = 1; k < TO; k++) cyc("c2_open2");
    bus2cac_bus_rsp[5:4] = 2'b01;
    bus2cac_addr[2*LA +: LA] = 26'h55;
    x.out[2] = 1'b0;
    x.cnt[2*CW +: CW] = 4'd1;
    cyc("c2_rsp_limit");

    // Reset clears counters, then 17 transactions on ch1 saturate at 15
    rst_n = 1'b0;
    zero_exp();
    cyc("reset2");
    rst_n = 1'b1;
    for (int n = 1; n <= 17; n++) begin
      cac2bus_bus_req[3:2] = 2'b01;
      cac2bus_addr[LA +: LA] = LA'(n);
      x.out[1] = 1'b1;
      cyc("sat_req");
      bus2cac_bus_rsp[3:2] = 2'b01;
      bus2cac_addr[LA +: LA] = LA'(n);
      x.out[1] = 1'b0;
      x.cnt[CW +: CW] = (n < 15) ? CW'(n) : 4'd15;
      cyc("sat_rsp");
    end

    // Reset while ch1 is open; the late response becomes an orphan
    cac2bus_bus_req[3:2] = 2'b01;
    cac2bus_addr[LA +: LA] = 26'h7;
    x.out[1] = 1'b1;
    cyc("rst_open");
    rst_n = 1'b0;
    zero_exp();
    cyc("rst_mid");
    rst_n = 1'b1;
    bus2cac_bus_rsp[3:2] = 2'b01;
    bus2cac_addr[LA +: LA] = 26'h7;
    x.err[1*6 + 2] = 1'b1;
    cyc("rst_orphan");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
